// File: rtl/charge_measure_pkg.sv
// Shared types and helpers for the charge measurement front-end.
// Holds the FSM state encoding and the settle-counter width calculation.
package charge_measure_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    ACCUM  = 1'b1
  } state_t;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_accumulator.sv
// Sums a window of 2**AVG_LOG2 accepted ADC samples and flags full-scale codes.
// sum/done/over are combinational views that include the sample being offered this cycle.
module sample_accumulator #(
  parameter int ADC_WIDTH = 10,
  parameter int AVG_LOG2  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic [ADC_WIDTH-1:0]          sample,
  output logic [ADC_WIDTH+AVG_LOG2-1:0] sum,
  output logic                          done,
  output logic                          over
);

  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int NUM_W = AVG_LOG2 + 1;
  localparam logic [NUM_W-1:0] LAST_IDX = NUM_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [NUM_W-1:0] r_count;
  logic             r_over;
  logic             w_full;

  assign w_full = (sample == {ADC_WIDTH{1'b1}});
  assign sum    = en ? (r_acc + ACC_W'(sample)) : r_acc;
  assign done   = en && (r_count == LAST_IDX);
  assign over   = r_over || (en && w_full);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching real flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_over  <= 1'b0;
    end else if (clr || done) begin
      r_acc   <= '0;
      r_count <= '0;
      r_over  <= 1'b0;
    end else if (en) begin
      r_acc   <= sum;
      r_count <= r_count + 1'b1;
      r_over  <= over;
    end
  end

endmodule

// File: rtl/charge_measure.sv
// Waits out a settling period after each i_ref change, then publishes the mean
// of every full window of ADC samples with a one-cycle ready pulse.
module charge_measure
  import charge_measure_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int ADC_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 64,
  parameter int AVG_LOG2      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 busy,
  output logic                 overrange
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES);
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BUS_WIDTH-1:0] r_i_ref_q;

  logic                 w_chg;
  logic                 w_clr;
  logic                 w_en;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_done;
  logic                 w_over;
  logic [ADC_WIDTH-1:0] w_mean;
  logic [BUS_WIDTH-1:0] w_q_next;

  assign w_chg = (i_ref != r_i_ref_q);
  // A reference change outranks a window-completing sample: it is never accepted.
  assign w_en  = adc_valid && (r_state == ACCUM) && !w_chg;
  assign w_clr = w_chg || (r_state == SETTLE);

  sample_accumulator #(
    .ADC_WIDTH (ADC_WIDTH),
    .AVG_LOG2  (AVG_LOG2)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .en     (w_en),
    .sample (adc_data),
    .sum    (w_sum),
    .done   (w_done),
    .over   (w_over)
  );

  // Truncating divide by the window length.
  assign w_mean = w_sum[ACC_W-1:AVG_LOG2];

  generate
    if (ADC_WIDTH >= BUS_WIDTH) begin : g_narrow
      assign w_q_next = w_mean[ADC_WIDTH-1 -: BUS_WIDTH];
    end else begin : g_widen
      assign w_q_next = {w_mean, {(BUS_WIDTH - ADC_WIDTH){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_ref_q  <= '0;
      r_state    <= SETTLE;
      r_cnt      <= SETTLE_LOAD;
      q_measured <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      overrange  <= 1'b0;
    end else begin
      r_i_ref_q <= i_ref;
      ready     <= 1'b0;
      overrange <= 1'b0;
      if (w_chg) begin
        r_state <= SETTLE;
        r_cnt   <= SETTLE_LOAD;
        busy    <= 1'b1;
      end else begin
        case (r_state)
          SETTLE: begin
            if (r_cnt == '0) begin
              r_state <= ACCUM;
              busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
              busy  <= 1'b1;
            end
          end
          ACCUM: begin
            busy <= 1'b0;
            if (w_done) begin
              q_measured <= w_q_next;
              ready      <= 1'b1;
              overrange  <= w_over;
            end
          end
          default: begin
            r_state <= SETTLE;
            r_cnt   <= SETTLE_LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_charge_measure.sv
// Directed bench for charge_measure with a cycle-level reference model compared on every falling edge.
module tb_charge_measure;

  localparam int BW     = 10;
  localparam int AW     = 10;
  localparam int SETTLE = 16;
  localparam int AVG    = 2;
  localparam int WIN    = 1 << AVG;
  localparam int FULL   = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] i_ref = 10'd200;
  logic [AW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [BW-1:0] q_measured;
  logic          ready;
  logic          busy;
  logic          overrange;

  charge_measure #(
    .BUS_WIDTH     (BW),
    .ADC_WIDTH     (AW),
    .SETTLE_CYCLES (SETTLE),
    .AVG_LOG2      (AVG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ref      (i_ref),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .q_measured (q_measured),
    .ready      (ready),
    .busy       (busy),
    .overrange  (overrange)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: settle countdown after each reference change, then a
  // running list of accepted samples that is averaged when it reaches WIN.
  typedef struct {
    int prev_ref;
    int settle_left;
    int n;
    int sum;
    bit seen_full;
    int q;
    bit ready;
    bit busy;
    bit ovr;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.prev_ref = 0; r.settle_left = SETTLE; r.n = 0; r.sum = 0; r.seen_full = 0;
    r.q = 0; r.ready = 0; r.busy = 0; r.ovr = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input int r, input int d, input bit v);
    model_t x = c;
    x.ready = 0;
    x.ovr   = 0;
    if (r != c.prev_ref) begin
      x.settle_left = SETTLE;
      x.n = 0; x.sum = 0; x.seen_full = 0;
      x.busy = 1;
    end else if (c.settle_left > 0) begin
      x.settle_left = c.settle_left - 1;
      x.busy = (x.settle_left > 0);
    end else if (v) begin
      x.sum = c.sum + d;
      x.n   = c.n + 1;
      x.seen_full = c.seen_full || (d == FULL);
      if (x.n == WIN) begin
        x.q     = x.sum / WIN;
        x.ready = 1;
        x.ovr   = x.seen_full;
        x.n = 0; x.sum = 0; x.seen_full = 0;
      end
    end
    x.prev_ref = r;
    return x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_step(m, int'(i_ref), int'(adc_data), adc_valid);
  end

  always @(negedge clk) begin
    if (rst) begin
      check("q_measured", int'(q_measured), m.q);
      check("ready", int'(ready), int'(m.ready));
      check("busy", int'(busy), int'(m.busy));
      check("overrange", int'(overrange), int'(m.ovr));
    end
  end

  // Apply inputs across one rising edge; returns at the following falling edge.
  task automatic drive(input int r, input int d, input bit v);
    i_ref     = BW'(r);
    adc_data  = AW'(d);
    adc_valid = v;
    @(negedge clk);
  endtask

  int busy_cnt;
  int ready_cnt;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset q", int'(q_measured), 0);
    check("reset ready/busy/ovr", int'({ready, busy, overrange}), 0);
    rst = 1'b1;

    // Steady reference, constant samples
    busy_cnt = 0;
    for (int i = 1; i <= 21; i++) begin
      drive(200, 300, 1);
      busy_cnt += int'(busy);
      if (i == 20) check("no early ready", int'(ready), 0);
      if (i == 21) begin
        check("first ready", int'(ready), 1);
        check("first q", int'(q_measured), 300);
      end
    end
    check("initial settle length", busy_cnt, 16);
    ready_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(200, 300, 1);
      ready_cnt += int'(ready);
      if (i == 4) check("ready spacing", int'(ready), 1);
    end
    check("free-running readies", ready_cnt, 2);

    // Truncating average
    drive(200, 100, 1);
    drive(200, 101, 1);
    drive(200, 102, 1);
    drive(200, 104, 1);
    check("trunc ready", int'(ready), 1);
    check("trunc q", int'(q_measured), 101);
    check("trunc ovr", int'(overrange), 0);

    // Reference change mid-window discards the partial window
    drive(200, 900, 1);
    drive(200, 900, 1);
    drive(500, 900, 1);
    check("chg busy", int'(busy), 1);
    check("chg no ready", int'(ready), 0);
    busy_cnt = 1;
    ready_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(500, 300, 1);
      busy_cnt += int'(busy);
      ready_cnt += int'(ready);
      if (i == 19) check("q held", int'(q_measured), 101);
    end
    check("resettle length", busy_cnt, 16);
    check("fresh window ready", ready_cnt, 1);
    check("fresh q", int'(q_measured), 300);

    // Full-scale sample
    drive(500, 1023, 1);
    drive(500, 10, 1);
    drive(500, 10, 1);
    drive(500, 10, 1);
    check("ovr ready", int'(ready), 1);
    check("ovr flag", int'(overrange), 1);
    check("ovr q", int'(q_measured), 263);
    for (int i = 0; i < 4; i++) drive(500, 10, 1);
    check("ovr cleared", int'(overrange), 0);
    check("q tens", int'(q_measured), 10);

    // Valid gaps
    ready_cnt = 0;
    drive(500, 40, 1); ready_cnt += int'(ready);
    drive(500, 40, 0); ready_cnt += int'(ready);
    drive(500, 40, 0); ready_cnt += int'(ready);
    drive(500, 40, 1); ready_cnt += int'(ready);
    drive(500, 40, 1); ready_cnt += int'(ready);
    drive(500, 40, 0); ready_cnt += int'(ready);
    check("gap no early ready", ready_cnt, 0);
    drive(500, 40, 1);
    check("gap ready", int'(ready), 1);
    check("gap q", int'(q_measured), 40);

    // Change coincident with the completing sample
    drive(500, 50, 1);
    drive(500, 50, 1);
    drive(500, 50, 1);
    drive(600, 50, 1);
    check("chg wins ready", int'(ready), 0);
    check("chg wins q", int'(q_measured), 40);
    check("chg wins busy", int'(busy), 1);

    // Asynchronous reset mid-window
    for (int i = 0; i < 16; i++) drive(600, 0, 0);
    check("accum entered", int'(busy), 0);
    drive(600, 1023, 1);
    drive(600, 1023, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async q", int'(q_measured), 0);
    check("async ready/busy/ovr", int'({ready, busy, overrange}), 0);
    @(negedge clk);
    rst = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      drive(600, 0, 0);
      busy_cnt += int'(busy);
    end
    check("post-reset settle", busy_cnt, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
